// File: rtl/quant_scheduler_pkg.sv
// Shared types and constants for the quantizer scheduler.
package quant_scheduler_pkg;

  // Colour component carried by a block and reported on the output tag
  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  // Quantizer table selects
  localparam logic [1:0] TSEL_LUMA   = 2'd0;
  localparam logic [1:0] TSEL_CHROMA = 2'd1;

  // One 8x8 block of 11-bit DCT coefficients
  localparam int COEF_W  = 11;
  localparam int BLK_DIM = 8;
  typedef logic [COEF_W-1:0] coef_t;
  typedef coef_t [BLK_DIM-1:0][BLK_DIM-1:0] blk_t;

  // Default quantizer latency and WAIT timeout
  localparam int LATENCY_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 8;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Luma uses table 0, both chroma components share table 1
  function automatic logic [1:0] tsel_for(input comp_e c);
    return (c == COMP_Y) ? TSEL_LUMA : TSEL_CHROMA;
  endfunction

endpackage

// File: rtl/quant_scheduler_rr_arb3.sv
// Three-way round-robin arbiter: search starts at i_ptr and wraps.
module rr_arb3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_grant
);

  // Pick the first requester at or after the pointer; an out-of-range pointer behaves like 0
  always_comb begin
    o_grant = 3'b000;
    case (i_ptr)
      2'd1: begin
        if (i_req[1])      o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      2'd2: begin
        if (i_req[2])      o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      default: begin
        if (i_req[0])      o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/quant_scheduler.sv
// Shares one quantizer among Y/Cb/Cr block producers, one block in flight at a time.
module quant_scheduler
  import quant_scheduler_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  i_req,
  input  blk_t        i_z_y,
  input  blk_t        i_z_cb,
  input  blk_t        i_z_cr,
  output logic [2:0]  o_ack,
  output blk_t        o_q_z,
  output logic        o_q_enable,
  output logic [1:0]  o_q_tsel,
  input  logic        i_q_out_enable,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [1:0]  o_out_comp,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic [15:0] o_blk_count
);

  // A TIMEOUT not above LATENCY is clamped so the timeout can never beat a healthy quantizer
  localparam int WAIT_SPAN = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY + 1;
  localparam int CNT_W     = $clog2(WAIT_SPAN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_SPAN - 1);

  state_e            r_state;
  state_e            w_next_state;
  comp_e             r_grant;
  logic [1:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [15:0]       r_blk_count;

  logic [2:0]        w_grant_onehot;
  comp_e             w_grant_comp;
  logic              w_timeout_hit;
  logic              w_out_fire;

  rr_arb3 u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_onehot)
  );

  // Convert the arbiter's one-hot grant into a component index
  always_comb begin
    w_grant_comp = COMP_Y;
    case (w_grant_onehot)
      3'b010:  w_grant_comp = COMP_CB;
      3'b100:  w_grant_comp = COMP_CR;
      default: w_grant_comp = COMP_Y;
    endcase
  end

  // A result pulse in the same cycle as the last WAIT count takes priority over the timeout
  assign w_timeout_hit = (r_state == ST_WAIT) && !i_q_out_enable && (r_cnt == CNT_LAST);
  assign w_out_fire    = (r_state == ST_OUTPUT) && i_out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; only IDLE can start a block, so one block is in flight at most
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (|i_req) w_next_state = ST_ISSUE;
      ST_ISSUE:  w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (i_q_out_enable)     w_next_state = ST_OUTPUT;
        else if (w_timeout_hit) w_next_state = ST_IDLE;
      end
      ST_OUTPUT: if (i_out_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the table select stays on the granted component until back in IDLE
  always_comb begin
    o_ack       = 3'b000;
    o_q_enable  = 1'b0;
    o_q_z       = '0;
    o_q_tsel    = TSEL_LUMA;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      ST_IDLE: o_busy = 1'b0;
      ST_ISSUE: begin
        o_ack      = 3'b001 << r_grant;
        o_q_enable = 1'b1;
        o_q_tsel   = tsel_for(r_grant);
        case (r_grant)
          COMP_Y:  o_q_z = i_z_y;
          COMP_CB: o_q_z = i_z_cb;
          COMP_CR: o_q_z = i_z_cr;
          default: o_q_z = '0;
        endcase
      end
      ST_WAIT: o_q_tsel = tsel_for(r_grant);
      ST_OUTPUT: begin
        o_q_tsel    = tsel_for(r_grant);
        o_out_valid = 1'b1;
      end
      default: o_busy = 1'b1;
    endcase
  end

  assign o_out_comp    = r_grant;
  assign o_err_timeout = r_err;
  assign o_blk_count   = r_blk_count;

  // Grant capture, WAIT counter, sticky error, completion count and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= COMP_Y;
      r_ptr       <= 2'd0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_blk_count <= 16'd0;
    end else begin
      if (r_state == ST_IDLE && |i_req) r_grant <= w_grant_comp;
      if (r_state == ST_ISSUE)          r_cnt <= '0;
      else if (r_state == ST_WAIT)      r_cnt <= r_cnt + 1'b1;
      if (w_timeout_hit)                r_err <= 1'b1;
      if (w_out_fire) begin
        r_blk_count <= r_blk_count + 16'd1;
        r_ptr       <= (r_grant == COMP_CR) ? 2'd0 : r_grant + 2'd1;
      end
    end
  end

endmodule
